// File: rtl/uart_wb_burst_bridge.sv
// UART byte-stream to Wishbone burst bridge: decodes read/write burst frames from an rx byte
// stream, runs one unpipelined Wishbone cycle per word, and reports data plus a status byte on tx.
module uart_wb_burst_bridge #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [7:0]  CMD_READ    = 8'h77,
    parameter logic [7:0]  CMD_WRITE   = 8'hAA,
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned RX_TIMEOUT  = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    busy
);

    localparam int unsigned DataBytes   = DATA_WIDTH / 8;
    localparam int unsigned AddrBytes   = ADDR_WIDTH / 8;
    localparam logic [2:0]  DataLast    = 3'(DataBytes - 1);
    localparam logic [2:0]  AddrLast    = 3'(AddrBytes - 1);
    localparam logic [31:0] AckLast     = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] RxLast      = 32'(RX_TIMEOUT - 1);
    localparam logic [7:0]  StatOk      = 8'h00;
    localparam logic [7:0]  StatTimeout = 8'hE1;
    localparam logic [7:0]  StatErr     = 8'hE2;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLen,
        StWdata,
        StWb,
        StTxData,
        StTxStat
    } state_e;

    state_e                  state_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              remain_q;
    logic [2:0]              byte_cnt_q;
    logic [DATA_WIDTH-1:0]   wr_shift_q;
    logic [DATA_WIDTH-1:0]   rd_shift_q;
    logic [DATA_WIDTH-1:0]   wb_dat_q;
    logic [31:0]             rx_tmr_q;
    logic [31:0]             ack_tmr_q;
    logic                    cyc_q;
    logic [DATA_WIDTH/8-1:0] sel_q;
    logic [7:0]              tx_data_q;
    logic                    tx_valid_q;

    logic [DATA_WIDTH-1:0]   wr_shift_next;
    logic [ADDR_WIDTH-1:0]   addr_shift_next;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic                    rx_expired;
    logic                    is_cmd;

    // Bytes arrive LSB first, so each new byte enters at the top and slides down.
    assign wr_shift_next   = (wr_shift_q >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));
    assign addr_shift_next = (addr_q >> 8) | (ADDR_WIDTH'(rx_data) << (ADDR_WIDTH - 8));
    assign addr_inc        = addr_q + ADDR_WIDTH'(ADDR_STEP);
    assign rx_expired      = (rx_tmr_q == RxLast);
    assign is_cmd          = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
            wr_shift_q <= '0;
            rd_shift_q <= '0;
            wb_dat_q   <= '0;
            rx_tmr_q   <= '0;
            ack_tmr_q  <= '0;
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_valid && is_cmd) begin
                        we_q       <= (rx_data == CMD_WRITE);
                        byte_cnt_q <= '0;
                        rx_tmr_q   <= '0;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    if (rx_valid) begin
                        addr_q   <= addr_shift_next;
                        rx_tmr_q <= '0;
                        if (byte_cnt_q == AddrLast) begin
                            byte_cnt_q <= '0;
                            state_q    <= StLen;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end else if (rx_expired) begin
                        state_q <= StIdle;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 32'd1;
                    end
                end
                StLen: begin
                    if (rx_valid) begin
                        remain_q   <= rx_data;
                        rx_tmr_q   <= '0;
                        byte_cnt_q <= '0;
                        if (we_q) begin
                            state_q <= StWdata;
                        end else begin
                            cyc_q     <= 1'b1;
                            sel_q     <= '1;
                            ack_tmr_q <= '0;
                            state_q   <= StWb;
                        end
                    end else if (rx_expired) begin
                        state_q <= StIdle;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 32'd1;
                    end
                end
                StWdata: begin
                    if (rx_valid) begin
                        wr_shift_q <= wr_shift_next;
                        rx_tmr_q   <= '0;
                        if (byte_cnt_q == DataLast) begin
                            byte_cnt_q <= '0;
                            wb_dat_q   <= wr_shift_next;
                            cyc_q      <= 1'b1;
                            sel_q      <= '1;
                            ack_tmr_q  <= '0;
                            state_q    <= StWb;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end else if (rx_expired) begin
                        state_q <= StIdle;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 32'd1;
                    end
                end
                StWb: begin
                    // err is tested first so it wins over a simultaneous ack.
                    if (wb_err_i) begin
                        cyc_q      <= 1'b0;
                        sel_q      <= '0;
                        tx_data_q  <= StatErr;
                        tx_valid_q <= 1'b1;
                        state_q    <= StTxStat;
                    end else if (wb_ack_i) begin
                        cyc_q  <= 1'b0;
                        sel_q  <= '0;
                        addr_q <= addr_inc;
                        if (!we_q) begin
                            tx_data_q  <= wb_dat_i[7:0];
                            rd_shift_q <= wb_dat_i >> 8;
                            tx_valid_q <= 1'b1;
                            byte_cnt_q <= '0;
                            state_q    <= StTxData;
                        end else if (remain_q == 8'd0) begin
                            tx_data_q  <= StatOk;
                            tx_valid_q <= 1'b1;
                            state_q    <= StTxStat;
                        end else begin
                            remain_q   <= remain_q - 8'd1;
                            byte_cnt_q <= '0;
                            rx_tmr_q   <= '0;
                            state_q    <= StWdata;
                        end
                    end else if (ack_tmr_q == AckLast) begin
                        cyc_q      <= 1'b0;
                        sel_q      <= '0;
                        tx_data_q  <= StatTimeout;
                        tx_valid_q <= 1'b1;
                        state_q    <= StTxStat;
                    end else begin
                        ack_tmr_q <= ack_tmr_q + 32'd1;
                    end
                end
                StTxData: begin
                    if (tx_ready) begin
                        if (byte_cnt_q == DataLast) begin
                            byte_cnt_q <= '0;
                            if (remain_q == 8'd0) begin
                                tx_data_q <= StatOk;
                                state_q   <= StTxStat;
                            end else begin
                                remain_q   <= remain_q - 8'd1;
                                tx_valid_q <= 1'b0;
                                cyc_q      <= 1'b1;
                                sel_q      <= '1;
                                ack_tmr_q  <= '0;
                                state_q    <= StWb;
                            end
                        end else begin
                            tx_data_q  <= rd_shift_q[7:0];
                            rd_shift_q <= rd_shift_q >> 8;
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                StTxStat: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q & we_q;
    assign wb_adr_o = addr_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_sel_o = sel_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_wb_burst_bridge.sv
// Randomized frame-level bench for uart_wb_burst_bridge: a reference model predicts bus
// transactions and tx bytes per frame; a memory slave and tx sink record what the DUT does.
module tb_uart_wb_burst_bridge;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 16;
    localparam int unsigned STEP   = 1;
    localparam int unsigned ACK_TO = 20;
    localparam int unsigned RX_TO  = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i, wb_err_i;
    logic          busy;

    uart_wb_burst_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CMD_READ   (8'h77),
        .CMD_WRITE  (8'hAA),
        .ADDR_STEP  (STEP),
        .ACK_TIMEOUT(ACK_TO),
        .RX_TIMEOUT (RX_TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o (wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] wwords [$];
    logic [15:0] exp_adr [$], obs_adr [$];
    logic        exp_we  [$], obs_we  [$];
    logic [31:0] exp_dat [$], obs_dat [$];
    logic [3:0]  obs_sel [$];
    logic [7:0]  exp_tx  [$], obs_tx  [$];

    // Slave plan for the current frame: word index fail_idx gets timeout(0), err(1) or err+ack(2).
    int fail_idx = -1;
    int fail_kind = 0;
    int max_delay = 0;
    int rdy_mode = 0;
    int bus_idx = 0;
    int cyc_hi = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap();
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int g);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = $urandom;
        repeat (g) tick();
    endtask

    task automatic clear_obs();
        obs_adr.delete(); obs_we.delete(); obs_dat.delete(); obs_sel.delete(); obs_tx.delete();
        bus_idx = 0;
        cyc_hi  = 0;
    endtask

    // Reference model: which words reach the bus, and which bytes come back on tx.
    task automatic build_expect(input bit we, input logic [15:0] addr, input int len,
                                input int fidx, input int fkind);
        int n_bus;
        int n_ok;
        n_bus = (fidx < 0) ? len + 1 : fidx + 1;
        n_ok  = (fidx < 0) ? len + 1 : fidx;
        exp_adr.delete(); exp_we.delete(); exp_dat.delete(); exp_tx.delete();
        for (int i = 0; i < n_bus; i++) begin
            exp_adr.push_back(addr + 16'(i * STEP));
            exp_we.push_back(we);
            exp_dat.push_back(we ? wwords[i] : 32'h0);
        end
        if (!we) begin
            for (int i = 0; i < n_ok; i++) begin
                for (int b = 0; b < 4; b++) begin
                    exp_tx.push_back(8'(mem[addr + 16'(i * STEP)] >> (8 * b)));
                end
            end
        end
        exp_tx.push_back(fidx < 0 ? 8'h00 : (fkind == 0 ? 8'hE1 : 8'hE2));
    endtask

    task automatic compare_all();
        check("n_bus", 64'(obs_adr.size()), 64'(exp_adr.size()));
        for (int i = 0; i < exp_adr.size() && i < obs_adr.size(); i++) begin
            check("wb_adr", 64'(obs_adr[i]), 64'(exp_adr[i]));
            check("wb_we", 64'(obs_we[i]), 64'(exp_we[i]));
            check("wb_sel", 64'(obs_sel[i]), 64'hF);
            if (exp_we[i]) check("wb_wdat", 64'(obs_dat[i]), 64'(exp_dat[i]));
        end
        check("n_tx", 64'(obs_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            check("tx_byte", 64'(obs_tx[i]), 64'(exp_tx[i]));
        end
    endtask

    task automatic run_frame(input bit we, input logic [15:0] addr, input int len,
                             input int fidx, input int fkind);
        clear_obs();
        fail_idx  = fidx;
        fail_kind = fkind;
        build_expect(we, addr, len, fidx, fkind);
        send_byte(we ? 8'hAA : 8'h77, gap());
        send_byte(addr[7:0], gap());
        send_byte(addr[15:8], gap());
        send_byte(8'(len), gap());
        if (we) begin
            for (int w = 0; w <= len; w++) begin
                for (int b = 0; b < 4; b++) begin
                    send_byte(wwords[w][8*b +: 8], (b == 3) ? 0 : gap());
                end
                // Next word's bytes would be dropped while the bus cycle is open.
                for (int k = 0; k < 10 && !wb_cyc_o; k++) tick();
                for (int k = 0; k < int'(ACK_TO) + 10 && wb_cyc_o; k++) tick();
                if (w == fidx) break;
            end
        end
        for (int k = 0; k < 4000 && busy; k++) tick();
        check("busy_idle", 64'(busy), 64'h0);
        repeat (2) tick();
        compare_all();
    endtask

    // Wishbone slave backed by mem; sampled and driven on the falling edge.
    bit          in_txn = 1'b0;
    int          wait_cnt = 0;
    int          cur_delay = 0;
    logic [15:0] t_adr;
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (rst_n && wb_cyc_o && wb_stb_o) begin
                cyc_hi++;
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_cnt  = 0;
                    cur_delay = int'($urandom_range(0, max_delay));
                    t_adr     = wb_adr_o;
                    obs_adr.push_back(wb_adr_o);
                    obs_we.push_back(wb_we_o);
                    obs_dat.push_back(wb_dat_o);
                    obs_sel.push_back(wb_sel_o);
                end
                if (!(bus_idx == fail_idx && fail_kind == 0) && wait_cnt == cur_delay) begin
                    check("wb_adr_hold", 64'(wb_adr_o), 64'(t_adr));
                    if (bus_idx == fail_idx) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = (fail_kind == 2);
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
                        else wb_dat_i = mem[wb_adr_o];
                    end
                    bus_idx++;
                end
                wait_cnt++;
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    initial begin
        int rcnt;
        rcnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: begin
                    rcnt++;
                    if (rcnt >= 3) begin
                        rcnt = 0;
                        tx_ready = !tx_ready;
                    end
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // tx sink: records accepted bytes and checks a stalled byte is held unchanged.
    initial begin
        bit         pend;
        logic [7:0] pend_d;
        pend = 1'b0;
        pend_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("tx_hold_valid", 64'(tx_valid), 64'h1);
                    if (tx_valid) check("tx_hold_data", 64'(tx_data), 64'(pend_d));
                end
                if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
                pend   = tx_valid && !tx_ready;
                pend_d = tx_data;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) tick();
        check("rst_cyc", 64'(wb_cyc_o), 64'h0);
        check("rst_stb", 64'(wb_stb_o), 64'h0);
        check("rst_we", 64'(wb_we_o), 64'h0);
        check("rst_adr", 64'(wb_adr_o), 64'h0);
        check("rst_dat", 64'(wb_dat_o), 64'h0);
        check("rst_sel", 64'(wb_sel_o), 64'h0);
        check("rst_txv", 64'(tx_valid), 64'h0);
        check("rst_txd", 64'(tx_data), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Two-word write at 0x0010
        wwords.delete();
        wwords.push_back($urandom);
        wwords.push_back($urandom);
        run_frame(1'b1, 16'h0010, 1, -1, 0);

        // Single read returning DEADBEEF
        mem[16'h1234] = 32'hDEADBEEF;
        run_frame(1'b0, 16'h1234, 0, -1, 0);

        // Ack timeout on the first word of a 3-word read
        run_frame(1'b0, 16'h0000, 2, 0, 0);
        check("timeout_cycles", 64'(cyc_hi), 64'(ACK_TO));

        // Error on the second word with address wrap
        run_frame(1'b0, 16'hFFFF, 2, 1, 1);

        // err and ack together on a write
        wwords.delete();
        for (int i = 0; i < 3; i++) wwords.push_back($urandom);
        run_frame(1'b1, 16'h4000, 2, 2, 2);

        // tx backpressure
        rdy_mode = 1;
        run_frame(1'b0, 16'h2000, 2, -1, 0);
        rdy_mode = 0;

        // Partial frame then silence
        clear_obs();
        fail_idx = -1;
        send_byte(8'hAA, 0);
        send_byte(8'h00, 0);
        repeat (RX_TO - 4) tick();
        check("rxto_still_busy", 64'(busy), 64'h1);
        repeat (8) tick();
        check("rxto_idle", 64'(busy), 64'h0);
        check("rxto_no_tx", 64'(obs_tx.size()), 64'h0);
        check("rxto_no_bus", 64'(obs_adr.size()), 64'h0);

        // Reset during an open bus cycle
        clear_obs();
        fail_idx  = 0;
        fail_kind = 0;
        send_byte(8'h77, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 10 && !wb_cyc_o; k++) tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rstwb_cyc", 64'(wb_cyc_o), 64'h0);
        check("rstwb_stb", 64'(wb_stb_o), 64'h0);
        check("rstwb_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        repeat (ACK_TO + 10) tick();
        check("rstwb_no_tx", 64'(obs_tx.size()), 64'h0);
        check("rstwb_one_bus", 64'(obs_adr.size()), 64'h1);

        // Randomized frames, preceded by junk bytes that IDLE must ignore
        for (int f = 0; f < 16; f++) begin
            bit          we;
            logic [15:0] addr;
            int          len;
            int          fidx;
            int          nj;
            logic [7:0]  junk;
            we        = 1'($urandom_range(0, 1));
            addr      = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            len       = int'($urandom_range(0, 4));
            fidx      = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len));
            max_delay = int'($urandom_range(0, 3));
            rdy_mode  = int'($urandom_range(0, 2));
            wwords.delete();
            for (int i = 0; i <= len; i++) wwords.push_back($urandom);
            nj = int'($urandom_range(0, 2));
            for (int j = 0; j < nj; j++) begin
                junk = 8'($urandom);
                if (junk == 8'h77 || junk == 8'hAA) junk = 8'h00;
                send_byte(junk, 0);
            end
            run_frame(we, addr, len, fidx, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
